// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer for the EX stage.
// Runs one bit per cycle on a shared WIDTH-bit add/sub and shift datapath and
// commits the HI/LO pair on entry to DONE. busy stalls the front of the pipe.
// Optional feature: define SIGNED_MULDIV_EN to enable signed MULT/DIV via op[1].
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LastCount = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic             is_div_q;
    logic [WIDTH-1:0] divisor_q;  // B: multiplicand added in / divisor subtracted
    // Multiply: P. Divide: R. The restoring remainder is always below B after
    // each iteration, so only the shifted trial value needs the extra bit.
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;   // Multiply: M. Divide: Q.

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

`ifdef SIGNED_MULDIV_EN
    logic             neg_res_q;  // negate product / quotient at commit
    logic             rem_neg_q;  // negate remainder at commit
    logic             sign_a;
    logic             sign_b;
`else
    logic             unused_op1;
    assign unused_op1 = op[1];
`endif

    // Operand conditioning at accept: magnitudes in signed mode, raw otherwise
    always_comb begin
`ifdef SIGNED_MULDIV_EN
        sign_a = op[1] & src_a[WIDTH-1];
        sign_b = op[1] & src_b[WIDTH-1];
        mag_a  = sign_a ? (~src_a + 1'b1) : src_a;
        mag_b  = sign_b ? (~src_b + 1'b1) : src_b;
`else
        mag_a  = src_a;
        mag_b  = src_b;
`endif
    end

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_borrow;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    // One shift-add or restoring-subtract iteration, plus commit-time result fixup
    always_comb begin
        mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, divisor_q} : '0);
        div_shift  = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_borrow = div_shift < {1'b0, divisor_q};
        // Low bits suffice: without a borrow the true difference is below B.
        div_diff   = div_shift[WIDTH-1:0] - divisor_q;

        if (is_div_q) begin
            step_hi = div_borrow ? div_shift[WIDTH-1:0] : div_diff;
            step_lo = {acc_lo_q[WIDTH-2:0], ~div_borrow};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end

        res_hi = step_hi;
        res_lo = step_lo;
`ifdef SIGNED_MULDIV_EN
        if (is_div_q) begin
            if (neg_res_q) res_lo = ~step_lo + 1'b1;
            if (rem_neg_q) res_hi = ~step_hi + 1'b1;
        end else if (neg_res_q) begin
            {res_hi, res_lo} = ~{step_hi, step_lo} + 1'b1;
        end
`endif
    end

    // Sequencer FSM with registered busy/done and HI/LO commit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            is_div_q    <= 1'b0;
            divisor_q   <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
`ifdef SIGNED_MULDIV_EN
            neg_res_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        count_q   <= '0;
                        is_div_q  <= op[0];
                        divisor_q <= mag_b;
                        acc_hi_q  <= '0;
                        acc_lo_q  <= mag_a;
`ifdef SIGNED_MULDIV_EN
                        neg_res_q <= sign_a ^ sign_b;
                        rem_neg_q <= sign_a;
`endif
                        if (op[0] && (src_b == '0)) begin
                            // Divide by zero skips RUN; result uses the raw dividend
                            state_q     <= StDone;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            hi          <= src_a;
                            lo          <= '1;
                        end else begin
                            state_q <= StRun;
                            busy    <= 1'b1;
                        end
                    end else begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                StRun: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    count_q  <= count_q + CNT_W'(1);
                    if (count_q == LastCount) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        hi      <= res_hi;
                        lo      <= res_lo;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (WIDTH=32).
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one op with a single-cycle start; return at the done cycle (lat=0 on timeout)
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        src_a = ~a;  // later input changes must not matter
        src_b = ~b;
        for (int k = 1; k <= 40; k++) begin
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        if (div_by_zero !== 1'b0) begin
            errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero);
        end
        if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        reset = 1'b0;
    endtask

    task automatic test_multu();
        int lat, nb;
        run_op(2'b00, 32'd3, 32'd5, lat, nb);
        checks += 4;
        if (lat !== 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", lat); end
        if (nb !== 32) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 32", nb); end
        if (hi !== 32'h0) begin errors++; $display("FAIL multu_hi: got %h want 0", hi); end
        if (lo !== 32'd15) begin errors++; $display("FAIL multu_lo: got %h want f", lo); end
        @(negedge clk);
        checks += 2;
        if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", done); end
        if (lo !== 32'd15) begin errors++; $display("FAIL lo_hold: got %h want f", lo); end
    endtask

    task automatic test_multu_max();
        int lat, nb;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nb);
        checks += 3;
        if (hi !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL multu_max_hi: got %h want fffffffe", hi);
        end
        if (lo !== 32'h0000_0001) begin
            errors++; $display("FAIL multu_max_lo: got %h want 00000001", lo);
        end
        if (div_by_zero !== 1'b0) begin
            errors++; $display("FAIL multu_max_dbz: got %b want 0", div_by_zero);
        end
        run_op(2'b00, 32'h1234_5678, 32'h0, lat, nb);
        checks += 3;
        if (lat !== 33) begin errors++; $display("FAIL mul_zero_latency: got %0d want 33", lat); end
        if (hi !== 32'h0) begin errors++; $display("FAIL mul_zero_hi: got %h want 0", hi); end
        if (lo !== 32'h0) begin errors++; $display("FAIL mul_zero_lo: got %h want 0", lo); end
    endtask

    task automatic test_divu();
        int lat, nb;
        run_op(2'b01, 32'd100, 32'd7, lat, nb);
        checks += 3;
        if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d want 33", lat); end
        if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want e", lo); end
        if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want 2", hi); end
        run_op(2'b01, 32'd5, 32'd0, lat, nb);
        checks += 5;
        if (lat !== 1) begin errors++; $display("FAIL div0_latency: got %0d want 1", lat); end
        if (nb !== 0) begin errors++; $display("FAIL div0_busy: got %0d want 0", nb); end
        if (hi !== 32'd5) begin errors++; $display("FAIL div0_hi: got %h want 5", hi); end
        if (lo !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div0_lo: got %h want ffffffff", lo);
        end
        if (div_by_zero !== 1'b1) begin
            errors++; $display("FAIL div0_flag: got %b want 1", div_by_zero);
        end
        run_op(2'b00, 32'd2, 32'd3, lat, nb);
        checks += 2;
        if (div_by_zero !== 1'b1) begin
            errors++; $display("FAIL div0_sticky: got %b want 1", div_by_zero);
        end
        if (lo !== 32'd6) begin errors++; $display("FAIL after_div0_lo: got %h want 6", lo); end
    endtask

    task automatic test_start_ignored();
        int ndone = 0;
        int first = 0;
        logic [31:0] cap_lo = '0;
        logic [31:0] cap_hi = '1;
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        src_a = 32'd6;
        src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 10 || k == 20) begin
                start = 1'b1;
                src_a = 32'h11;
                src_b = 32'h22;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (first == 0) begin
                    first  = k;
                    cap_lo = lo;
                    cap_hi = hi;
                end
            end
            @(negedge clk);
        end
        checks += 4;
        if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
        if (first !== 33) begin errors++; $display("FAIL ignore_latency: got %0d want 33", first); end
        if (cap_lo !== 32'd42) begin errors++; $display("FAIL ignore_lo: got %h want 2a", cap_lo); end
        if (cap_hi !== 32'h0) begin errors++; $display("FAIL ignore_hi: got %h want 0", cap_hi); end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        src_a = 32'd3;
        src_b = 32'd5;
        @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        checks += 2;
        if (lat !== 33) begin errors++; $display("FAIL b2b_first_latency: got %0d want 33", lat); end
        if (lo !== 32'd15) begin errors++; $display("FAIL b2b_first_lo: got %h want f", lo); end
        // start still high in DONE: second op accepted on this cycle's edge
        op    = 2'b01;
        src_a = 32'd100;
        src_b = 32'd7;
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble: got %b want 1", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b want 0", done); end
        start = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        checks += 3;
        if (lat !== 33) begin errors++; $display("FAIL b2b_second_latency: got %0d want 33", lat); end
        if (lo !== 32'd14) begin errors++; $display("FAIL b2b_second_lo: got %h want e", lo); end
        if (hi !== 32'd2) begin errors++; $display("FAIL b2b_second_hi: got %h want 2", hi); end
    endtask

    task automatic test_reset_mid();
        int lat, nb;
        int stray = 0;
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        src_a = 32'd1000;
        src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        checks += 1;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_running: got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
        if (hi !== 32'h0) begin errors++; $display("FAIL midrst_hi: got %h want 0", hi); end
        if (lo !== 32'h0) begin errors++; $display("FAIL midrst_lo: got %h want 0", lo); end
        if (div_by_zero !== 1'b0) begin
            errors++; $display("FAIL midrst_dbz: got %b want 0", div_by_zero);
        end
        for (int k = 0; k < 40; k++) begin
            if (busy || done) stray++;
            @(negedge clk);
        end
        checks += 1;
        if (stray !== 0) begin errors++; $display("FAIL midrst_idle: got %0d active cycles want 0", stray); end
        run_op(2'b00, 32'd2, 32'd2, lat, nb);
        checks += 2;
        if (lat !== 33) begin errors++; $display("FAIL midrst_mul_latency: got %0d want 33", lat); end
        if (lo !== 32'd4) begin errors++; $display("FAIL midrst_mul_lo: got %h want 4", lo); end
    endtask

`ifdef SIGNED_MULDIV_EN
    task automatic test_signed();
        int lat, nb;
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, nb);
        checks += 3;
        if (lat !== 33) begin errors++; $display("FAIL sdiv_latency: got %0d want 33", lat); end
        if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_lo: got %h want fffffffd", lo); end
        if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv_hi: got %h want ffffffff", hi); end
        run_op(2'b10, 32'hFFFF_FFFD, 32'd4, lat, nb);
        checks += 2;
        if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL smul_hi: got %h want ffffffff", hi); end
        if (lo !== 32'hFFFF_FFF4) begin errors++; $display("FAIL smul_lo: got %h want fffffff4", lo); end
        run_op(2'b11, 32'hFFFF_FFF9, 32'd0, lat, nb);
        checks += 2;
        if (hi !== 32'hFFFF_FFF9) begin errors++; $display("FAIL sdiv0_hi: got %h want fffffff9", hi); end
        if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv0_lo: got %h want ffffffff", lo); end
    endtask
`else
    task automatic test_op1_ignored();
        int lat, nb;
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, nb);
        checks += 3;
        if (lat !== 33) begin errors++; $display("FAIL udiv_op1_latency: got %0d want 33", lat); end
        if (lo !== 32'h7FFF_FFFC) begin errors++; $display("FAIL udiv_op1_lo: got %h want 7ffffffc", lo); end
        if (hi !== 32'd1) begin errors++; $display("FAIL udiv_op1_hi: got %h want 1", hi); end
        run_op(2'b10, 32'hFFFF_FFFD, 32'd4, lat, nb);
        checks += 2;
        if (hi !== 32'd3) begin errors++; $display("FAIL umul_op1_hi: got %h want 3", hi); end
        if (lo !== 32'hFFFF_FFF4) begin errors++; $display("FAIL umul_op1_lo: got %h want fffffff4", lo); end
    endtask
`endif

    initial begin
        test_reset();
        test_multu();
        test_multu_max();
        test_divu();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
`ifdef SIGNED_MULDIV_EN
        test_signed();
`else
        test_op1_ignored();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
